// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder slice.
// The state encoding and counter width are shared by the FSM and its bench.
package dm_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dm_array.sv
// Word-organised storage with a synchronous byte-enabled write port and a
// combinational read port. Contents are deliberately left unreset.
module dm_array
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, commits
// it after LATENCY cycles and holds the registered response until retired.
module dm_resp
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [BE_W-1:0]   lat_be;
  logic [WORD_W-1:0] lat_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic              accept;
  logic              commit;
  logic              arr_we;
  logic              unused_addr_bits;

  // Byte-lane bits of the address carry no meaning for a word memory.
  assign unused_addr_bits = ^req_addr[1:0];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;
  assign commit    = (state == WAIT) && (cnt == '0);
  assign arr_we    = commit && lat_we && (lat_be != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid) next_state = WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, latency counter and the registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr[ADDR_W+1:2];
        lat_be    <= req_be;
        lat_wdata <= req_wdata;
        cnt       <= CNT_W'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (commit) begin
        rsp_err   <= (lat_be == '0);
        rsp_rdata <= (!lat_we && (lat_be != '0)) ? arr_rdata : '0;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  dm_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (lat_be),
    .waddr (lat_addr),
    .wdata (lat_wdata),
    .raddr (lat_addr),
    .rdata (arr_rdata)
  );

endmodule
